// File: rtl/vid_pkg.sv
// Shared display-path constants, sequencer state encoding and button indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vid_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned ROWS_DEF     = 4;
  localparam int unsigned COLS_DEF     = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    PLAYER = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

endpackage

// File: rtl/frame_update_sequencer_if.sv
// Bundle between the frame sequencer and its display-side peers.
// Latency: n/a (wiring only); optional collision ports under COLLISION_EN.
// Backpressure: none, all signals are level or single-cycle.
interface frame_update_sequencer_if
  import vid_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
);

  logic [31:0] vCount;
  logic [3:0]  btns;
  logic        pause;
  logic [31:0] player_objWidth;
  logic [31:0] player_objHeight;
  logic [31:0] hOffset [ROWS][COLS];
  logic [31:0] vOffset [ROWS][COLS];
  logic [31:0] player_hOffset;
  logic [31:0] player_vOffset;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        overrun;
`ifdef COLLISION_EN
  logic [31:0] objWidth  [ROWS][COLS];
  logic [31:0] objHeight [ROWS][COLS];
  logic        hit;
  logic [4:0]  hit_idx;

  modport master (
    output vCount, btns, pause, player_objWidth, player_objHeight, objWidth, objHeight,
    input  hOffset, vOffset, player_hOffset, player_vOffset, busy, frame_cnt, overrun,
           hit, hit_idx
  );
  modport slave (
    input  vCount, btns, pause, player_objWidth, player_objHeight, objWidth, objHeight,
    output hOffset, vOffset, player_hOffset, player_vOffset, busy, frame_cnt, overrun,
           hit, hit_idx
  );
`else
  modport master (
    output vCount, btns, pause, player_objWidth, player_objHeight,
    input  hOffset, vOffset, player_hOffset, player_vOffset, busy, frame_cnt, overrun
  );
  modport slave (
    input  vCount, btns, pause, player_objWidth, player_objHeight,
    output hOffset, vOffset, player_hOffset, player_vOffset, busy, frame_cnt, overrun
  );
`endif

endinterface

// File: rtl/frame_update_sequencer_sat_step.sv
// Saturating move of one player axis: decrement clamps at 0, increment clamps at span-size.
// Latency: combinational.
// Backpressure: none.
module sat_step (
  input  logic [31:0] cur,
  input  logic [31:0] step,
  input  logic [31:0] span,
  input  logic [31:0] size,
  input  logic        dec,
  input  logic        inc,
  output logic [31:0] nxt
);

  logic [31:0] limit;
  logic [31:0] sum;

  // Opposing buttons cancel; an object as large as the screen pins the limit at 0.
  always_comb begin
    limit = (size >= span) ? 32'd0 : span - size;
    sum   = cur + step;
    nxt   = cur;
    if (dec && !inc) begin
      nxt = (cur < step) ? 32'd0 : cur - step;
    end else if (inc && !dec) begin
      nxt = (sum > limit) ? limit : sum;
    end
  end

endmodule

// File: rtl/frame_update_sequencer.sv
// Per-frame scroll/player update, started at vertical blank; optional COLLISION_EN adds hit/hit_idx.
// Latency: ROWS*COLS+3 clks from the blank-start pulse to busy low.
// Backpressure: none; a blank start while busy is dropped and flagged by sticky overrun.
module frame_update_sequencer
  import vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned ROWS        = ROWS_DEF,
  parameter int unsigned COLS        = COLS_DEF,
  parameter int unsigned SCROLL_DIV  = 2,
  parameter int unsigned PLAYER_STEP = 4
) (
  input  logic clk,
  input  logic rst,
  frame_update_sequencer_if.slave bus
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  seq_state_t       state;
  seq_state_t       stateNext;
  logic             blk;
  logic             blkQ;
  logic             trig;
  logic [ROW_W-1:0] rowIdx;
  logic [COL_W-1:0] colIdx;
  logic             lastCol;
  logic             lastSlot;
  logic [3:0]       btnsQ;
  logic             pauseQ;
  logic [7:0]       divCnt;
  logic             scrollEn;
  logic [31:0]      curOff;
  logic [31:0]      stepPx;
  logic [31:0]      sumOff;
  logic [31:0]      newOff;
  logic [31:0]      playerXNext;
  logic [31:0]      playerYNext;

  assign blk      = (bus.vCount >= 32'(V_ACTIVE));
  assign trig     = blk & ~blkQ;
  assign lastCol  = (colIdx == COL_W'(COLS - 1));
  assign lastSlot = lastCol && (rowIdx == ROW_W'(ROWS - 1));
  assign scrollEn = (divCnt == 8'(SCROLL_DIV - 1)) && !pauseQ;

  // Scroll arithmetic for the slot currently addressed; wrap keeps offsets below H_ACTIVE.
  always_comb begin
    curOff = bus.hOffset[rowIdx][colIdx];
    stepPx = scrollEn ? (32'(rowIdx) + 32'd1) : 32'd0;
    sumOff = curOff + stepPx;
    newOff = (sumOff >= 32'(H_ACTIVE)) ? (sumOff - 32'(H_ACTIVE)) : sumOff;
  end

  sat_step uStepY (
    .cur  (bus.player_vOffset),
    .step (32'(PLAYER_STEP)),
    .span (32'(V_ACTIVE)),
    .size (bus.player_objHeight),
    .dec  (btnsQ[BTN_UP]),
    .inc  (btnsQ[BTN_DOWN]),
    .nxt  (playerYNext)
  );

  sat_step uStepX (
    .cur  (bus.player_hOffset),
    .step (32'(PLAYER_STEP)),
    .span (32'(H_ACTIVE)),
    .size (bus.player_objWidth),
    .dec  (btnsQ[BTN_LEFT]),
    .inc  (btnsQ[BTN_RIGHT]),
    .nxt  (playerXNext)
  );

  // State register; reset abandons any pass in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next state: one slot per clk in SCAN, then a single player cycle and a bookkeeping cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (trig) stateNext = SCAN;
      SCAN:    if (lastSlot) stateNext = PLAYER;
      PLAYER:  stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs decoded from state; vertical slot offsets are reserved and tied to 0.
  always_comb begin
    bus.busy = (state != IDLE);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.vOffset[r][c] = 32'd0;
      end
    end
  end

  // Blank-edge history, per-pass latches, slot walk and scroll write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blkQ        <= 1'b0;
      btnsQ       <= 4'd0;
      pauseQ      <= 1'b0;
      rowIdx      <= '0;
      colIdx      <= '0;
      bus.overrun <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          bus.hOffset[r][c] <= 32'd0;
        end
      end
    end else begin
      blkQ <= blk;
      if (trig && state == IDLE) begin
        btnsQ  <= bus.btns;
        pauseQ <= bus.pause;
        rowIdx <= '0;
        colIdx <= '0;
      end
      if (trig && state != IDLE) bus.overrun <= 1'b1;
      if (state == SCAN) begin
        bus.hOffset[rowIdx][colIdx] <= newOff;
        if (lastCol) begin
          colIdx <= '0;
          rowIdx <= rowIdx + 1'b1;
        end else begin
          colIdx <= colIdx + 1'b1;
        end
      end
    end
  end

  // Player move, pass counter and scroll divider advance once per completed scan.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.player_hOffset <= 32'd0;
      bus.player_vOffset <= 32'd0;
      bus.frame_cnt      <= 16'd0;
      divCnt             <= 8'd0;
    end else if (state == PLAYER) begin
      bus.player_hOffset <= playerXNext;
      bus.player_vOffset <= playerYNext;
      bus.frame_cnt      <= bus.frame_cnt + 16'd1;
      divCnt             <= (divCnt == 8'(SCROLL_DIV - 1)) ? 8'd0 : divCnt + 8'd1;
    end
  end

`ifdef COLLISION_EN
  logic [31:0] pxQ;
  logic [31:0] pyQ;
  logic [31:0] pwQ;
  logic [31:0] phQ;
  logic        overlap;

  // Half-open box test of the addressed slot (pre-update offset) against the latched player box.
  always_comb begin
    overlap = (curOff < pxQ + pwQ) && (pxQ < curOff + bus.objWidth[rowIdx][colIdx]) &&
              (bus.vOffset[rowIdx][colIdx] < pyQ + phQ) &&
              (pyQ < bus.vOffset[rowIdx][colIdx] + bus.objHeight[rowIdx][colIdx]);
  end

  // Player box frozen at pass start; first overlapping slot index is kept until the next pass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pxQ         <= 32'd0;
      pyQ         <= 32'd0;
      pwQ         <= 32'd0;
      phQ         <= 32'd0;
      bus.hit     <= 1'b0;
      bus.hit_idx <= 5'd0;
    end else if (trig && state == IDLE) begin
      pxQ         <= bus.player_hOffset;
      pyQ         <= bus.player_vOffset;
      pwQ         <= bus.player_objWidth;
      phQ         <= bus.player_objHeight;
      bus.hit     <= 1'b0;
      bus.hit_idx <= 5'd0;
    end else if (state == SCAN && overlap && !bus.hit) begin
      bus.hit     <= 1'b1;
      bus.hit_idx <= 5'(32'(rowIdx) * 32'(COLS) + 32'(colIdx));
    end
  end
`endif

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Directed bench for frame_update_sequencer: reset, scroll wrap, player saturation, overrun.
// Latency: n/a.
// Backpressure: n/a.
module tb_frame_update_sequencer;

  localparam int ROWS = 4;
  localparam int COLS = 6;
  localparam int HA   = 640;
  localparam int VA   = 480;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_update_sequencer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  frame_update_sequencer #(.SCROLL_DIV(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errCnt  = 0;
  int chkCnt  = 0;
  int nScroll = 0;  // passes that advanced the scroll
  int frames  = 0;  // completed passes
  int lastLat = 0;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkSlots(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        checkVal($sformatf("%s hOff[%0d][%0d]", tag, r, c), bus.hOffset[r][c],
                 32'(((r + 1) * nScroll) % HA));
        checkVal($sformatf("%s vOff[%0d][%0d]", tag, r, c), bus.vOffset[r][c], 32'd0);
      end
    end
  endtask

  // Waits for busy low after the blank start; lat counts clks from the first vCount>=V_ACTIVE edge.
  task automatic waitIdle(output int lat);
    for (lat = 1; lat <= 100; lat++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.busy) break;
    end
    if (lat > 100) checkVal("passTimeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic runPass(input logic [3:0] b, input logic p);
    int lat;
    bus.btns   = b;
    bus.pause  = p;
    bus.vCount = 32'(VA - 1);
    stepClk(2);
    bus.vCount = 32'(VA);
    waitIdle(lat);
    lastLat = lat;
    @(posedge clk);
    #1;
    bus.vCount = 32'd0;
    stepClk(1);
    frames++;
    if (!p) nScroll++;
  endtask

  initial begin
    bus.vCount           = 32'd0;
    bus.btns             = 4'hF;
    bus.pause            = 1'b0;
    bus.player_objWidth  = 32'd40;
    bus.player_objHeight = 32'd40;
`ifdef COLLISION_EN
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.objWidth[r][c]  = 32'd0;
        bus.objHeight[r][c] = 32'd0;
      end
    end
`endif

    // Reset with all buttons held.
    rst = 1'b0;
    stepClk(3);
    rst = 1'b1;
    stepClk(1);
    checkVal("rstBusy", 32'(bus.busy), 32'd0);
    checkVal("rstFrame", 32'(bus.frame_cnt), 32'd0);
    checkVal("rstOverrun", 32'(bus.overrun), 32'd0);
    checkVal("rstPx", bus.player_hOffset, 32'd0);
    checkVal("rstPy", bus.player_vOffset, 32'd0);
    checkSlots("rst");

    // First pass: row r advances by r+1.
    runPass(4'h0, 1'b0);
    checkVal("latency", 32'(lastLat), 32'd27);
    checkVal("p1Frame", 32'(bus.frame_cnt), 32'd1);
    checkVal("p1Row0", bus.hOffset[0][5], 32'd1);
    checkVal("p1Row3", bus.hOffset[3][0], 32'd4);
    checkVal("p1Px", bus.player_hOffset, 32'd0);
    checkSlots("p1");

    // Paused pass: scroll frozen, player still moves down.
    runPass(4'b0010, 1'b1);
    checkVal("pausePy", bus.player_vOffset, 32'd4);
    checkVal("pauseFrame", 32'(bus.frame_cnt), 32'd2);
    checkSlots("pause");

    // Vertical limit 480-478=2: down clamps to 2, up from 2 clamps to 0, up at 0 stays 0.
    bus.player_objHeight = 32'd478;
    runPass(4'b0010, 1'b0);
    checkVal("downClamp", bus.player_vOffset, 32'd2);
    runPass(4'b0001, 1'b0);
    checkVal("upFrom2", bus.player_vOffset, 32'd0);
    runPass(4'b0001, 1'b0);
    checkVal("upAt0", bus.player_vOffset, 32'd0);

    // Horizontal: reach x=2, then width 40 steps to 598 and clamps at 600.
    bus.player_objWidth = 32'd638;
    runPass(4'b1000, 1'b0);
    checkVal("rightLim2", bus.player_hOffset, 32'd2);
    bus.player_objWidth = 32'd40;
    repeat (149) runPass(4'b1000, 1'b0);
    checkVal("right598", bus.player_hOffset, 32'd598);
    runPass(4'b1000, 1'b0);
    checkVal("right600", bus.player_hOffset, 32'd600);

    // Player wider than the screen: limit is 0.
    bus.player_objWidth = 32'd700;
    runPass(4'b1000, 1'b0);
    checkVal("wideLim0", bus.player_hOffset, 32'd0);

    // Opposing buttons cancel per axis.
    bus.player_objWidth  = 32'd40;
    bus.player_objHeight = 32'd40;
    runPass(4'b1010, 1'b0);
    checkVal("drPx", bus.player_hOffset, 32'd4);
    checkVal("drPy", bus.player_vOffset, 32'd4);
    runPass(4'hF, 1'b0);
    checkVal("allPx", bus.player_hOffset, 32'd4);
    checkVal("allPy", bus.player_vOffset, 32'd4);
    checkSlots("all");
    runPass(4'b1101, 1'b0);
    checkVal("ulrPx", bus.player_hOffset, 32'd4);
    checkVal("ulrPy", bus.player_vOffset, 32'd0);
    checkVal("midFrame", 32'(bus.frame_cnt), 32'(frames));

    // Scroll wrap boundaries: row3 636->0 at pass 160, row2 639->2 at pass 214.
    while (nScroll < 159) runPass(4'h0, 1'b0);
    checkVal("row3At159", bus.hOffset[3][2], 32'd636);
    runPass(4'h0, 1'b0);
    checkVal("row3Wrap", bus.hOffset[3][2], 32'd0);
    checkSlots("n160");
    while (nScroll < 213) runPass(4'h0, 1'b0);
    checkVal("row2At213", bus.hOffset[2][4], 32'd639);
    runPass(4'h0, 1'b0);
    checkVal("row2Wrap", bus.hOffset[2][4], 32'd2);
    checkVal("row3At214", bus.hOffset[3][4], 32'd216);
    checkSlots("n214");

    // Second blank start 10 clks into the pass: flagged, ignored.
    begin
      int lat;
      bus.btns   = 4'h0;
      bus.pause  = 1'b0;
      bus.vCount = 32'(VA - 1);
      stepClk(2);
      bus.vCount = 32'(VA);
      stepClk(3);
      bus.vCount = 32'd0;
      stepClk(7);
      bus.vCount = 32'(VA);
      waitIdle(lat);
      stepClk(5);
      frames++;
      nScroll++;
      checkVal("ovrFlag", 32'(bus.overrun), 32'd1);
      checkVal("ovrBusy", 32'(bus.busy), 32'd0);
      checkVal("ovrFrame", 32'(bus.frame_cnt), 32'(frames));
      checkSlots("ovr");
      bus.vCount = 32'd0;
      stepClk(2);
    end

    // Reset in the middle of a scan discards the pass and clears overrun.
    bus.vCount = 32'(VA - 1);
    stepClk(2);
    bus.vCount = 32'(VA);
    stepClk(6);
    checkVal("midScanBusy", 32'(bus.busy), 32'd1);
    rst        = 1'b0;
    bus.vCount = 32'd0;
    stepClk(1);
    rst = 1'b1;
    stepClk(1);
    nScroll = 0;
    frames  = 0;
    checkVal("rst2Busy", 32'(bus.busy), 32'd0);
    checkVal("rst2Frame", 32'(bus.frame_cnt), 32'd0);
    checkVal("rst2Overrun", 32'(bus.overrun), 32'd0);
    checkVal("rst2Px", bus.player_hOffset, 32'd0);
    checkVal("rst2Py", bus.player_vOffset, 32'd0);
    checkSlots("rst2");

    // Sequencer runs normally after the reset.
    runPass(4'h0, 1'b0);
    checkVal("postLat", 32'(lastLat), 32'd27);
    checkVal("postFrame", 32'(bus.frame_cnt), 32'd1);
    checkSlots("post");

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
